regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writers:
- the main pipeline writeback stage (highest priority, never backpressured);
- the multi-cycle multiply/divide unit (MDU) result path, buffered in a small FIFO.

It also keeps a 32-bit pending-write scoreboard of MDU destinations so the hazard unit can stall readers. It sits between the writeback stage, the MDU and the register file's WA/WD/WE inputs.

Parameters:
- WIDTH, 32: data width of write data.
- DEPTH, 4: MDU result FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8: consecutive cycles with FIFO non-empty and pipeline writing before pipe_stall is raised.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- pipe_we  in  1  pipeline writeback request.
- pipe_wa  in  5  pipeline destination register.
- pipe_wd  in  WIDTH  pipeline write data.
- pipe_stall  out  1  registered; pipeline must hold pipe_we=0 in any cycle this is 1.
- mdu_issue  in  1  MDU operation issued; marks its destination pending.
- mdu_issue_wa  in  5  destination of the issued MDU operation.
- mdu_valid  in  1  MDU result available.
- mdu_wa  in  5  MDU result destination.
- mdu_wd  in  WIDTH  MDU result data.
- mdu_ready  out  1  result accepted this cycle when mdu_valid=1.
- chk_ra1  in  5  hazard-check read address 1.
- chk_ra2  in  5  hazard-check read address 2.
- chk_busy  out  1  1 when either chk address is pending.
- pend_vec  out  32  scoreboard bits; bit 0 is always 0.
- rf_we  out  1  to register file WE.
- rf_wa  out  5  to register file WA.
- rf_wd  out  WIDTH  to register file WD.
- waw_err  out  1  sticky WAW violation flag (see Optional Feature).

Behaviour:
- Reset, while RST=1 at posedge:
  - FIFO emptied, scoreboard cleared, starvation counter cleared.
  - pipe_stall=0, waw_err=0.
  - The rf_* outputs are combinational. While RST=1 they are forced to rf_we=0, rf_wa=0, rf_wd=0.
  - Reset mid-operation discards buffered MDU results without writing them.
- Write-port grant, evaluated combinationally each cycle:
  1. pipe_we=1: rf_* = pipe_*.
  2. Otherwise, FIFO non-empty: rf_* = FIFO head, and the head pops at posedge.
  3. Otherwise, mdu_valid=1 with FIFO empty: bypass. rf_* = mdu_*, zero latency, no enqueue.
  4. Otherwise rf_we=0.
- mdu_ready = !RST && (FIFO not full || FIFO pops this cycle).
  - An accepted result that is not bypassed is enqueued at posedge.
  - Simultaneous pop and push on a full FIFO is legal; the count is unchanged.
- Address 0:
  - A pipeline write to $0 still drives rf_we=1; the register file drops it.
  - An MDU result with wa=0 is accepted (mdu_ready normal) and discarded, never enqueued or bypassed.
  - mdu_issue with wa=0 sets nothing.
- Scoreboard:
  - Set: pend_vec[mdu_issue_wa] is set at posedge on mdu_issue.
  - Clear: a bit is cleared at posedge when an MDU-sourced grant (FIFO pop or bypass) writes that register.
  - Set and clear of the same bit in the same cycle: set wins.
  - chk_busy is combinational from pend_vec.
  - The hazard unit guarantees no re-issue to an already-pending register.
- Starvation:
  - The counter increments each cycle that pipe_we=1 and the FIFO is non-empty; otherwise it clears.
  - When the counter reaches STARVE_LIMIT-1 and increments, pipe_stall=1 for exactly the next cycle and the counter clears.
  - If pipe_we=1 while pipe_stall=1, that is a protocol error. The pipeline still wins the grant; assertion only.
- Ordering: FIFO entries retire in arrival order; the pipeline write always retires in its own cycle.

Optional Feature:
- Macro WB_ARB_WAW_CHECK_EN.
- Defined: waw_err is set and held until RST if pipe_we=1 with pipe_wa!=0 and pend_vec[pipe_wa]=1 (pipeline write would later be overwritten by an older MDU result).
- Not defined: waw_err is tied 0 and no comparison logic is built.

Decomposition:
- Package regfile_pkg:
  - NUM_REGS=32, REG_ADDR_W=5, REG_ZERO=0, REG_SP=29, SP_RESET=32'h100;
  - typedef of a write request struct {we, wa, wd}.
- One sub-module, wb_fifo:
  - parameterised WIDTH+5 bits wide by DEPTH;
  - push/pop/full/empty/head outputs;
  - synchronous active-high reset.

Test Plan:
- Idle FIFO, mdu_valid=1 wa=5 wd=0xAAAA with pipe_we=0 -> same cycle rf_we=1 rf_wa=5 rf_wd=0xAAAA; mdu_ready=1; pend_vec[5] clears at posedge.
- Pipe writes wa=3 every cycle; 5 MDU results wa=8..12 with DEPTH=4 -> four results enqueued, then mdu_ready=0. After 8 conflict cycles pipe_stall=1 for one cycle, and that cycle writes wa=8.
- mdu_issue wa=7, then chk_ra1=7 -> chk_busy=1 next cycle. After the wa=7 result is written -> chk_busy=0.
- mdu_issue wa=9 in the same cycle the wa=9 bypass retires -> pend_vec[9] stays 1.
- With WB_ARB_WAW_CHECK_EN: pend_vec[4]=1, then pipe writes wa=4 -> waw_err=1 and stays 1. Without the macro -> waw_err=0.
- Two results queued, RST=1 for one cycle -> rf_we=0 during reset; afterwards FIFO empty, pend_vec=0, neither queued result is ever written.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - register file constants and write request type
package regfile_pkg;

   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_ZERO   = 0;
   localparam int REG_SP     = 29;
   localparam logic [31:0] SP_RESET = 32'h100;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] wa;
      logic [31:0]           wd;
   } wr_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback, MDU, hazard-check and register file port bundle
interface regfile_wb_arbiter_if #(parameter int WIDTH = 32);
   import regfile_pkg::*;

   logic                  pipe_we;
   logic [REG_ADDR_W-1:0] pipe_wa;
   logic [WIDTH-1:0]      pipe_wd;
   logic                  pipe_stall;
   logic                  mdu_issue;
   logic [REG_ADDR_W-1:0] mdu_issue_wa;
   logic                  mdu_valid;
   logic [REG_ADDR_W-1:0] mdu_wa;
   logic [WIDTH-1:0]      mdu_wd;
   logic                  mdu_ready;
   logic [REG_ADDR_W-1:0] chk_ra1;
   logic [REG_ADDR_W-1:0] chk_ra2;
   logic                  chk_busy;
   logic [NUM_REGS-1:0]   pend_vec;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_wa;
   logic [WIDTH-1:0]      rf_wd;
   logic                  waw_err;

   modport slave (
      input  pipe_we, pipe_wa, pipe_wd, mdu_issue, mdu_issue_wa,
      input  mdu_valid, mdu_wa, mdu_wd, chk_ra1, chk_ra2,
      output pipe_stall, mdu_ready, chk_busy, pend_vec,
      output rf_we, rf_wa, rf_wd, waw_err
   );

   modport master (
      output pipe_we, pipe_wa, pipe_wd, mdu_issue, mdu_issue_wa,
      output mdu_valid, mdu_wa, mdu_wd, chk_ra1, chk_ra2,
      input  pipe_stall, mdu_ready, chk_busy, pend_vec,
      input  rf_we, rf_wa, rf_wd, waw_err
   );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - MDU result FIFO, power-of-two depth, show-ahead head
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;

   // Pointer and occupancy update; a push and pop together leave count unchanged.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Storage has no reset; only occupied entries are ever read.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with MDU pending scoreboard (option: WB_ARB_WAW_CHECK_EN)
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   regfile_wb_arbiter_if.slave  bus
);

   localparam int EW = WIDTH + REG_ADDR_W;
   localparam int CW = ($clog2(STARVE_LIMIT) > 0) ? $clog2(STARVE_LIMIT) : 1;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [EW-1:0]         fifo_head;
   logic                  bypass;
   logic                  mdu_zero;
   logic                  ready;
   logic                  we_c;
   logic [REG_ADDR_W-1:0] wa_c;
   logic [WIDTH-1:0]      wd_c;
   logic [NUM_REGS-1:0]   pend;
   logic [NUM_REGS-1:0]   set_mask;
   logic [NUM_REGS-1:0]   clr_mask;
   logic [CW-1:0]         starve_cnt;
   logic                  stall_q;

   assign mdu_zero = (bus.mdu_wa == REG_ADDR_W'(REG_ZERO));

   // Write-port grant: pipeline, then FIFO head, then zero-latency bypass.
   always_comb begin
      we_c     = 1'b0;
      wa_c     = '0;
      wd_c     = '0;
      fifo_pop = 1'b0;
      bypass   = 1'b0;
      if (!RST) begin
         if (bus.pipe_we) begin
            we_c = 1'b1;
            wa_c = bus.pipe_wa;
            wd_c = bus.pipe_wd;
         end else if (!fifo_empty) begin
            we_c     = 1'b1;
            wa_c     = fifo_head[EW-1:WIDTH];
            wd_c     = fifo_head[WIDTH-1:0];
            fifo_pop = 1'b1;
         end else if (bus.mdu_valid && !mdu_zero) begin
            we_c   = 1'b1;
            wa_c   = bus.mdu_wa;
            wd_c   = bus.mdu_wd;
            bypass = 1'b1;
         end
      end
   end

   assign ready     = !RST && (!fifo_full || fifo_pop);
   assign fifo_push = bus.mdu_valid && ready && !bypass && !mdu_zero;

   wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({bus.mdu_wa, bus.mdu_wd}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // Pending set/clear masks; MDU-sourced grants retire their destination.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (bus.mdu_issue) begin
         set_mask[bus.mdu_issue_wa] = 1'b1;
      end
      if (fifo_pop) begin
         clr_mask[fifo_head[EW-1:WIDTH]] = 1'b1;
      end
      if (bypass) begin
         clr_mask[bus.mdu_wa] = 1'b1;
      end
   end

   // Scoreboard: set wins over clear, register zero never pending.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend <= '0;
      end else begin
         pend <= ((pend & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
      end
   end

   // Starvation counter: one stall cycle after STARVE_LIMIT blocked cycles in a row.
   always_ff @(posedge CLK) begin
      if (RST) begin
         starve_cnt <= '0;
         stall_q    <= 1'b0;
      end else if (bus.pipe_we && !fifo_empty) begin
         if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
            starve_cnt <= '0;
            stall_q    <= 1'b1;
         end else begin
            starve_cnt <= starve_cnt + CW'(1);
            stall_q    <= 1'b0;
         end
      end else begin
         starve_cnt <= '0;
         stall_q    <= 1'b0;
      end
   end

   pipe_hold_on_stall: assert property (@(posedge CLK) disable iff (RST) stall_q |-> !bus.pipe_we);

`ifdef WB_ARB_WAW_CHECK_EN
   logic waw_q;

   // Sticky flag: a pipeline write to a register an older MDU result will overwrite.
   always_ff @(posedge CLK) begin
      if (RST) begin
         waw_q <= 1'b0;
      end else if (bus.pipe_we && (bus.pipe_wa != REG_ADDR_W'(REG_ZERO)) && pend[bus.pipe_wa]) begin
         waw_q <= 1'b1;
      end
   end

   assign bus.waw_err = waw_q;
`else
   assign bus.waw_err = 1'b0;
`endif

   assign bus.rf_we      = we_c;
   assign bus.rf_wa      = wa_c;
   assign bus.rf_wd      = wd_c;
   assign bus.mdu_ready  = ready;
   assign bus.pipe_stall = stall_q;
   assign bus.pend_vec   = pend;
   assign bus.chk_busy   = pend[bus.chk_ra1] | pend[bus.chk_ra2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

`ifdef WB_ARB_WAW_CHECK_EN
   localparam logic EXP_WAW = 1'b1;
`else
   localparam logic EXP_WAW = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   logic       pipe_run  = 1'b0;
   logic [4:0] pipe_addr = 5'd0;
   int         pipe_seq  = 0;

   wr_req_t pipe_q[$];
   wr_req_t mdu_q[$];
   wr_req_t e;

   regfile_wb_arbiter_if #(.WIDTH(32)) bus ();

   regfile_wb_arbiter #(.WIDTH(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic mdu_send(input logic [4:0] wa, input logic [31:0] wd, output int waits);
      bus.mdu_valid = 1'b1;
      bus.mdu_wa    = wa;
      bus.mdu_wd    = wd;
      waits         = 0;
      forever begin
         @(negedge CLK);
         if (bus.mdu_ready) break;
         waits++;
         if (waits >= 40) begin
            chk("mdu_send_ready", {63'd0, bus.mdu_ready}, 64'd1);
            break;
         end
      end
   endtask

   // Pipeline driver: honours pipe_stall and records each issued write.
   initial begin
      bus.pipe_we = 1'b0;
      bus.pipe_wa = '0;
      bus.pipe_wd = '0;
      forever begin
         @(posedge CLK);
         #1;
         if (pipe_run && !bus.pipe_stall) begin
            bus.pipe_we = 1'b1;
            bus.pipe_wa = pipe_addr;
            bus.pipe_wd = 32'h3000_0000 + pipe_seq;
            pipe_seq++;
            pipe_q.push_back('{we: 1'b1, wa: bus.pipe_wa, wd: bus.pipe_wd});
         end else begin
            bus.pipe_we = 1'b0;
         end
      end
   end

   // Monitor: records accepted MDU results, then checks every register-file write.
   always @(negedge CLK) begin
      if (RST) begin
         chk("rst_rf_we", {63'd0, bus.rf_we}, 64'd0);
         if (bus.pipe_we && pipe_q.size() > 0) void'(pipe_q.pop_front());
      end else begin
         if (bus.mdu_valid && bus.mdu_ready && bus.mdu_wa != 5'd0)
            mdu_q.push_back('{we: 1'b1, wa: bus.mdu_wa, wd: bus.mdu_wd});
         if (bus.pipe_we) begin
            chk("pipe_grant_we", {63'd0, bus.rf_we}, 64'd1);
            if (pipe_q.size() > 0) begin
               e = pipe_q.pop_front();
               chk("pipe_wa", {59'd0, bus.rf_wa}, {59'd0, e.wa});
               chk("pipe_wd", {32'd0, bus.rf_wd}, {32'd0, e.wd});
            end
         end else if (bus.rf_we) begin
            chk("mdu_write_expected", {63'd0, mdu_q.size() > 0}, 64'd1);
            if (mdu_q.size() > 0) begin
               e = mdu_q.pop_front();
               chk("mdu_wa", {59'd0, bus.rf_wa}, {59'd0, e.wa});
               chk("mdu_wd", {32'd0, bus.rf_wd}, {32'd0, e.wd});
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      int w;
      bus.mdu_issue = 1'b0; bus.mdu_issue_wa = '0;
      bus.mdu_valid = 1'b0; bus.mdu_wa = '0; bus.mdu_wd = '0;
      bus.chk_ra1 = '0; bus.chk_ra2 = '0;

      // reset state
      @(negedge CLK);
      chk("rst_pend_vec", {32'd0, bus.pend_vec}, 64'd0);
      chk("rst_pipe_stall", {63'd0, bus.pipe_stall}, 64'd0);
      chk("rst_waw_err", {63'd0, bus.waw_err}, 64'd0);
      chk("rst_mdu_ready", {63'd0, bus.mdu_ready}, 64'd0);
      step(); RST = 1'b0;

      // bypass with idle FIFO
      step(); bus.mdu_issue = 1'b1; bus.mdu_issue_wa = 5'd5;
      step(); bus.mdu_issue = 1'b0;
      bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd5; bus.mdu_wd = 32'hAAAA;
      @(negedge CLK);
      chk("byp_rf_we", {63'd0, bus.rf_we}, 64'd1);
      chk("byp_rf_wa", {59'd0, bus.rf_wa}, 64'd5);
      chk("byp_rf_wd", {32'd0, bus.rf_wd}, 64'hAAAA);
      chk("byp_ready", {63'd0, bus.mdu_ready}, 64'd1);
      chk("byp_pend5_before", {63'd0, bus.pend_vec[5]}, 64'd1);
      step(); bus.mdu_valid = 1'b0;
      @(negedge CLK);
      chk("byp_pend5_after", {63'd0, bus.pend_vec[5]}, 64'd0);

      // MDU result to $0 accepted and dropped
      step(); bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd0; bus.mdu_wd = 32'hDEAD;
      @(negedge CLK);
      chk("zero_mdu_ready", {63'd0, bus.mdu_ready}, 64'd1);
      chk("zero_mdu_rf_we", {63'd0, bus.rf_we}, 64'd0);
      step(); bus.mdu_valid = 1'b0;
      bus.mdu_issue = 1'b1; bus.mdu_issue_wa = 5'd0;
      step(); bus.mdu_issue = 1'b0;
      @(negedge CLK);
      chk("zero_issue_pend", {32'd0, bus.pend_vec}, 64'd0);

      // pipeline write to $0 still drives the port
      pipe_addr = 5'd0; pipe_run = 1'b1;
      step(); pipe_run = 1'b0;
      step();

      // stack pointer bypass
      step(); bus.mdu_valid = 1'b1; bus.mdu_wa = 5'(REG_SP); bus.mdu_wd = SP_RESET;
      step(); bus.mdu_valid = 1'b0;

      // chk_busy tracking
      step(); bus.mdu_issue = 1'b1; bus.mdu_issue_wa = 5'd7;
      step(); bus.mdu_issue = 1'b0; bus.chk_ra1 = 5'd7;
      @(negedge CLK);
      chk("busy_ra1", {63'd0, bus.chk_busy}, 64'd1);
      step(); bus.chk_ra1 = 5'd1; bus.chk_ra2 = 5'd7;
      @(negedge CLK);
      chk("busy_ra2", {63'd0, bus.chk_busy}, 64'd1);
      step(); bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd7; bus.mdu_wd = 32'h7777;
      step(); bus.mdu_valid = 1'b0;
      @(negedge CLK);
      chk("busy_cleared", {63'd0, bus.chk_busy}, 64'd0);
      bus.chk_ra2 = 5'd0;

      // same-cycle set and clear: set wins
      step(); bus.mdu_issue = 1'b1; bus.mdu_issue_wa = 5'd9;
      bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd9; bus.mdu_wd = 32'h9999;
      step(); bus.mdu_issue = 1'b0; bus.mdu_valid = 1'b0;
      @(negedge CLK);
      chk("setwins_pend9", {63'd0, bus.pend_vec[9]}, 64'd1);
      step(); bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd9; bus.mdu_wd = 32'h9A9A;
      step(); bus.mdu_valid = 1'b0;
      @(negedge CLK);
      chk("setwins_cleared", {32'd0, bus.pend_vec}, 64'd0);

      // WAW detection
      step(); bus.mdu_issue = 1'b1; bus.mdu_issue_wa = 5'd4;
      step(); bus.mdu_issue = 1'b0; pipe_addr = 5'd4; pipe_run = 1'b1;
      step(); pipe_run = 1'b0;
      step(); step();
      @(negedge CLK);
      chk("waw_set", {63'd0, bus.waw_err}, {63'd0, EXP_WAW});
      step(); bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd4; bus.mdu_wd = 32'h4444;
      step(); bus.mdu_valid = 1'b0;
      step();
      @(negedge CLK);
      chk("waw_sticky", {63'd0, bus.waw_err}, {63'd0, EXP_WAW});
      chk("waw_pend_clear", {32'd0, bus.pend_vec}, 64'd0);

      // FIFO fill, backpressure and starvation stall
      pipe_addr = 5'd3; pipe_run = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         mdu_send(5'(8 + i), 32'h8000_0000 + i, w);
         chk("fifo_fill_wait", 64'(w), 64'd0);
         step();
      end
      mdu_send(5'd12, 32'h8000_0004, w);
      chk("full_wait_cycles", 64'(w), 64'd5);
      chk("stall_raised", {63'd0, bus.pipe_stall}, 64'd1);
      chk("stall_rf_wa", {59'd0, bus.rf_wa}, 64'd8);
      chk("stall_rf_we", {63'd0, bus.rf_we}, 64'd1);
      step(); bus.mdu_valid = 1'b0;
      @(negedge CLK);
      chk("stall_one_cycle", {63'd0, bus.pipe_stall}, 64'd0);
      pipe_run = 1'b0;
      repeat (8) step();
      chk("drain_ready", {63'd0, bus.mdu_ready}, 64'd1);

      // reset with results queued
      step(); pipe_addr = 5'd3; pipe_run = 1'b1;
      bus.mdu_issue = 1'b1; bus.mdu_issue_wa = 5'd13;
      step(); bus.mdu_issue = 1'b0;
      mdu_send(5'd13, 32'h1313, w);
      step();
      mdu_send(5'd14, 32'h1414, w);
      step(); bus.mdu_valid = 1'b0; RST = 1'b1; pipe_run = 1'b0;
      mdu_q.delete();
      @(negedge CLK);
      chk("midrst_rf_we", {63'd0, bus.rf_we}, 64'd0);
      chk("midrst_ready", {63'd0, bus.mdu_ready}, 64'd0);
      step(); RST = 1'b0;
      @(negedge CLK);
      chk("postrst_pend", {32'd0, bus.pend_vec}, 64'd0);
      chk("postrst_rf_we", {63'd0, bus.rf_we}, 64'd0);
      chk("postrst_ready", {63'd0, bus.mdu_ready}, 64'd1);
      chk("postrst_waw", {63'd0, bus.waw_err}, 64'd0);
      repeat (6) step();

      chk("pipe_q_drained", 64'(pipe_q.size()), 64'd0);
      chk("mdu_q_drained", 64'(mdu_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
